ysyx_23060111_lsu: RTL and testbench
====================================

// Module: ysyx_23060111_lsu
// PURPOSE
//  Load/store unit between the core execute stage and ysyx_23060111_mem (DPI memory).
//  Accepts one load/store at a time on a valid/ready request port and drives the word-aligned memory
//  port (combinational read, write on posedge). Generates byte masks, shifts store data, extracts and
//  sign/zero-extends load data, flags misaligned or illegal accesses, and returns a response on a
//  valid/ready response port.
// PARAMETERS
//  MISALIGN_ERR  1  1: misaligned access -> error response, no memory access; 0: low addr bits forced to alignment
// PORTS
//  clk           in   1   clock; all state changes on posedge
//  rst_n         in   1   asynchronous, active-low reset
//  req_valid     in   1   request present
//  req_ready     out  1   LSU can accept request (=1 only in IDLE)
//  req_wen       in   1   1 store, 0 load
//  req_addr      in   32  byte address
//  req_wdata     in   32  store data, right-justified
//  req_size      in   2   0 byte, 1 half, 2 word, 3 illegal
//  req_unsigned  in   1   load zero-extend (1) / sign-extend (0)
//  resp_valid    out  1   response present
//  resp_ready    in   1   consumer takes response
//  resp_rdata    out  32  extended load data; 0 for stores and errors
//  resp_err      out  1   misaligned / illegal size
//  m_raddr       out  32  word-aligned read address ({addr[31:2],2'b00})
//  m_ren         out  1   read enable
//  m_rdata       in   32  read data, valid same cycle as m_ren
//  m_waddr       out  32  word-aligned write address
//  m_wdata       out  32  store data shifted to byte lane
//  m_wmask       out  32  byte enables in [3:0], [31:4]=0
//  m_wen         out  1   write enable, sampled by memory at posedge
// BEHAVIOUR
//  FSM: IDLE -> ACCESS -> RESP -> IDLE; error path IDLE -> RESP.
//  IDLE: req_ready=1. On req_valid&&req_ready at posedge: latch wen/addr/wdata/size/unsigned.
//    Legal -> ACCESS; illegal -> RESP with resp_err=1, resp_rdata=0.
//  Illegal: size==3 always; MISALIGN_ERR=1 and (half && addr[0]) or (word && addr[1:0]!=0).
//    With MISALIGN_ERR=0, offset is forced (half: off&2'b10, word: 2'b00); only size 3 errs.
//  ACCESS (exactly one cycle): load -> m_ren=1, m_raddr=aligned addr; m_rdata captured at end of cycle.
//    Store -> m_wen=1, m_waddr=aligned addr, m_wdata=wdata<<(8*off),
//    m_wmask=(byte 4'b0001 | half 4'b0011 | word 4'b1111)<<off. Memory commits at the closing posedge.
//  Load extract: s=m_rdata>>(8*off); byte s[7:0], half s[15:0], word s; extend per req_unsigned.
//  RESP: resp_valid=1, resp_rdata/resp_err held stable until resp_valid&&resp_ready, then IDLE.
//  No new request accepted in same cycle as response handshake (one-cycle bubble; req_ready=0 in RESP).
//  Latency: accept at edge N -> memory access cycle N+1 -> resp_valid high in cycle N+2.
//  m_ren, m_wen are 0 in every state except ACCESS; address/data/mask outputs 0 outside ACCESS.
//  Reset (async, rst_n=0): state=IDLE, resp_valid=0, resp_err=0, resp_rdata=0, m_ren=0, m_wen=0,
//    all m_* address/data/mask=0; req_ready=1 but no request accepted while rst_n=0.
//  Reset during ACCESS: m_wen drops immediately; a store whose posedge has not occurred is not performed.
//  Reset during RESP: pending response discarded.
// TESTING
//  1 store word addr=0x80000004 data=0xDEADBEEF -> ACCESS: m_waddr=0x80000004 m_wmask=0xF m_wdata=0xDEADBEEF; resp_err=0 at N+2.
//  2 store byte addr=0x80000003 data=0x000000AB -> m_waddr=0x80000000 m_wmask=0x8 m_wdata=0xAB000000.
//  3 load with m_rdata=0x80F17F00, addr off 1: byte signed -> 0x0000007F; off 2 byte signed -> 0xFFFFFFF1;
//    half off 2 unsigned -> 0x000080F1; half off 2 signed -> 0xFFFF80F1.
//  4 load word addr=0x80000002 (MISALIGN_ERR=1) -> no m_ren/m_wen pulse, resp_err=1, resp_rdata=0 in cycle N+1.
//  5 resp_ready held 0 for 5 cycles -> resp_valid and data stable, req_ready=0, new req_valid ignored.
//  6 rst_n low mid-ACCESS of a store -> m_wen=0 immediately, memory unchanged, FSM in IDLE after release.

Source files
------------

// File: rtl/ysyx_23060111_lsu.sv
// Load/store unit: one request at a time, IDLE -> ACCESS -> RESP, word-aligned memory port.
// Latency: accept at edge N, memory access in cycle N+1, response in cycle N+2. Errors respond in cycle N+1.
module ysyx_23060111_lsu #(
   parameter bit MISALIGN_ERR = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wen,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] m_raddr,
   output logic        m_ren,
   input  logic [31:0] m_rdata,
   output logic [31:0] m_waddr,
   output logic [31:0] m_wdata,
   output logic [31:0] m_wmask,
   output logic        m_wen
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t      state;
   logic        wen_q;
   logic        unsigned_q;
   logic [1:0]  size_q;
   logic [1:0]  off_q;

   logic [1:0]  off_c;
   logic        illegal_c;
   logic [3:0]  mask_c;
   logic [31:0] ld_shift;
   logic [31:0] ld_ext;

   assign req_ready = (state == IDLE);

   // Without MISALIGN_ERR the low address bits are forced to the access alignment.
   always_comb begin
      off_c     = req_addr[1:0];
      illegal_c = 1'b0;
      mask_c    = 4'b1111;
      case (req_size)
         2'd0: mask_c = 4'b0001;
         2'd1: begin
            mask_c = 4'b0011;
            if (MISALIGN_ERR) illegal_c = req_addr[0];
            else              off_c     = {req_addr[1], 1'b0};
         end
         2'd2: begin
            if (MISALIGN_ERR) illegal_c = |req_addr[1:0];
            else              off_c     = 2'b00;
         end
         default: illegal_c = 1'b1;
      endcase
   end

   always_comb begin
      ld_shift = m_rdata >> {off_q, 3'b000};
      case (size_q)
         2'd0:    ld_ext = unsigned_q ? {24'h0, ld_shift[7:0]}
                                      : {{24{ld_shift[7]}}, ld_shift[7:0]};
         2'd1:    ld_ext = unsigned_q ? {16'h0, ld_shift[15:0]}
                                      : {{16{ld_shift[15]}}, ld_shift[15:0]};
         default: ld_ext = ld_shift;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         wen_q      <= 1'b0;
         unsigned_q <= 1'b0;
         size_q     <= 2'd0;
         off_q      <= 2'd0;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= 32'h0;
         m_raddr    <= 32'h0;
         m_ren      <= 1'b0;
         m_waddr    <= 32'h0;
         m_wdata    <= 32'h0;
         m_wmask    <= 32'h0;
         m_wen      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  wen_q      <= req_wen;
                  unsigned_q <= req_unsigned;
                  size_q     <= req_size;
                  off_q      <= off_c;
                  if (illegal_c) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= 32'h0;
                  end else begin
                     state <= ACCESS;
                     if (req_wen) begin
                        m_wen   <= 1'b1;
                        m_waddr <= {req_addr[31:2], 2'b00};
                        m_wdata <= req_wdata << {off_c, 3'b000};
                        m_wmask <= {28'h0, mask_c << off_c};
                     end else begin
                        m_ren   <= 1'b1;
                        m_raddr <= {req_addr[31:2], 2'b00};
                     end
                  end
               end
            end
            ACCESS: begin
               // Memory read data is combinational, so it is captured on the closing edge.
               state      <= RESP;
               resp_valid <= 1'b1;
               resp_err   <= 1'b0;
               resp_rdata <= wen_q ? 32'h0 : ld_ext;
               m_ren      <= 1'b0;
               m_raddr    <= 32'h0;
               m_wen      <= 1'b0;
               m_waddr    <= 32'h0;
               m_wdata    <= 32'h0;
               m_wmask    <= 32'h0;
            end
            RESP: begin
               if (resp_ready) begin
                  state      <= IDLE;
                  resp_valid <= 1'b0;
                  resp_err   <= 1'b0;
                  resp_rdata <= 32'h0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_23060111_lsu.sv
// Directed bench for ysyx_23060111_lsu with a small byte-masked word memory model.
module tb_ysyx_23060111_lsu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_wen;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] m_raddr;
   logic        m_ren;
   logic [31:0] m_rdata;
   logic [31:0] m_waddr;
   logic [31:0] m_wdata;
   logic [31:0] m_wmask;
   logic        m_wen;

   logic [31:0] mem [0:15];
   int          n_cmp = 0;
   int          n_bad = 0;

   ysyx_23060111_lsu #(.MISALIGN_ERR(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
      .req_unsigned(req_unsigned),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err),
      .m_raddr(m_raddr), .m_ren(m_ren), .m_rdata(m_rdata),
      .m_waddr(m_waddr), .m_wdata(m_wdata), .m_wmask(m_wmask), .m_wen(m_wen)
   );

   always #5 clk = ~clk;

   assign m_rdata = m_ren ? mem[m_raddr[5:2]] : 32'h0;

   always @(posedge clk) begin
      if (m_wen)
         for (int b = 0; b < 4; b++)
            if (m_wmask[b]) mem[m_waddr[5:2]][8*b +: 8] <= m_wdata[8*b +: 8];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h want %08h", tag, got, exp);
      end
   endtask

   // Presents one request and returns just after its accepting edge.
   task automatic issue(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input logic uns);
      @(negedge clk);
      req_valid    = 1'b1;
      req_wen      = wen;
      req_addr     = addr;
      req_wdata    = wdata;
      req_size     = size;
      req_unsigned = uns;
      chk("req_ready_at_accept", {31'h0, req_ready}, 32'h1);
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic ack;
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
   endtask

   task automatic store_word(input logic [31:0] addr, input logic [31:0] data);
      issue(1'b1, addr, data, 2'd2, 1'b0);
      @(negedge clk);
      @(negedge clk);
      ack();
   endtask

   task automatic load_chk(input string tag, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] exp);
      issue(1'b0, addr, 32'h0, size, uns);
      @(negedge clk);
      chk({tag, "_ren"}, {31'h0, m_ren}, 32'h1);
      chk({tag, "_raddr"}, m_raddr, {addr[31:2], 2'b00});
      @(negedge clk);
      chk({tag, "_rdata"}, resp_rdata, exp);
      chk({tag, "_err"}, {31'h0, resp_err}, 32'h0);
      ack();
   endtask

   initial begin
      rst_n        = 1'b0;
      req_valid    = 1'b1;
      req_wen      = 1'b1;
      req_addr     = 32'h80000000;
      req_wdata    = 32'hFFFFFFFF;
      req_size     = 2'd2;
      req_unsigned = 1'b0;
      resp_ready   = 1'b0;

      // Reset state, with a request held high that must not be taken.
      repeat (2) @(negedge clk);
      chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
      chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
      chk("rst_m_wen", {31'h0, m_wen}, 32'h0);
      chk("rst_m_ren", {31'h0, m_ren}, 32'h0);
      chk("rst_m_wmask", m_wmask, 32'h0);
      chk("rst_rdata", resp_rdata, 32'h0);
      req_valid = 1'b0;
      rst_n     = 1'b1;
      @(negedge clk);
      chk("post_rst_resp_valid", {31'h0, resp_valid}, 32'h0);

      store_word(32'h80000000, 32'h0);
      store_word(32'h8000000C, 32'h0);
      store_word(32'h80000008, 32'h80F17F00);

      // Store word.
      issue(1'b1, 32'h80000004, 32'hDEADBEEF, 2'd2, 1'b0);
      @(negedge clk);
      chk("sw_wen", {31'h0, m_wen}, 32'h1);
      chk("sw_waddr", m_waddr, 32'h80000004);
      chk("sw_wmask", m_wmask, 32'h0000000F);
      chk("sw_wdata", m_wdata, 32'hDEADBEEF);
      @(negedge clk);
      chk("sw_resp_valid", {31'h0, resp_valid}, 32'h1);
      chk("sw_resp_err", {31'h0, resp_err}, 32'h0);
      chk("sw_resp_rdata", resp_rdata, 32'h0);
      chk("sw_wen_off", {31'h0, m_wen}, 32'h0);
      chk("sw_mem", mem[1], 32'hDEADBEEF);
      ack();

      // Store byte at lane 3.
      issue(1'b1, 32'h80000003, 32'h000000AB, 2'd0, 1'b0);
      @(negedge clk);
      chk("sb_waddr", m_waddr, 32'h80000000);
      chk("sb_wmask", m_wmask, 32'h00000008);
      chk("sb_wdata", m_wdata, 32'hAB000000);
      @(negedge clk);
      chk("sb_mem", mem[0], 32'hAB000000);
      ack();

      // Loads from word 0x80F17F00.
      load_chk("lb_off1", 32'h80000009, 2'd0, 1'b0, 32'h0000007F);
      load_chk("lb_off2", 32'h8000000A, 2'd0, 1'b0, 32'hFFFFFFF1);
      load_chk("lbu_off3", 32'h8000000B, 2'd0, 1'b1, 32'h00000080);
      load_chk("lhu_off2", 32'h8000000A, 2'd1, 1'b1, 32'h000080F1);
      load_chk("lh_off2", 32'h8000000A, 2'd1, 1'b0, 32'hFFFF80F1);
      load_chk("lw", 32'h80000008, 2'd2, 1'b0, 32'h80F17F00);

      // Misaligned word load answers in cycle N+1 without touching memory.
      issue(1'b0, 32'h80000002, 32'h0, 2'd2, 1'b0);
      @(negedge clk);
      chk("mis_ren", {31'h0, m_ren}, 32'h0);
      chk("mis_wen", {31'h0, m_wen}, 32'h0);
      chk("mis_valid", {31'h0, resp_valid}, 32'h1);
      chk("mis_err", {31'h0, resp_err}, 32'h1);
      chk("mis_rdata", resp_rdata, 32'h0);
      ack();

      // Size 3 store is illegal and must not write.
      issue(1'b1, 32'h80000000, 32'h11223344, 2'd3, 1'b0);
      @(negedge clk);
      chk("ill_err", {31'h0, resp_err}, 32'h1);
      chk("ill_wen", {31'h0, m_wen}, 32'h0);
      ack();
      chk("ill_mem", mem[0], 32'hAB000000);

      // Stalled response: stable output, no new request taken.
      issue(1'b0, 32'h80000008, 32'h0, 2'd2, 1'b0);
      @(negedge clk);
      req_valid = 1'b1;
      req_wen   = 1'b1;
      req_addr  = 32'h8000000C;
      req_wdata = 32'h55555555;
      req_size  = 2'd2;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_valid", {31'h0, resp_valid}, 32'h1);
         chk("stall_rdata", resp_rdata, 32'h80F17F00);
         chk("stall_req_ready", {31'h0, req_ready}, 32'h0);
         chk("stall_wen", {31'h0, m_wen}, 32'h0);
      end
      req_valid = 1'b0;
      ack();
      @(negedge clk);
      chk("stall_done_valid", {31'h0, resp_valid}, 32'h0);
      chk("stall_done_ready", {31'h0, req_ready}, 32'h1);
      chk("stall_mem", mem[3], 32'h0);

      // Reset in the middle of a store access cancels the write.
      issue(1'b1, 32'h8000000C, 32'h12345678, 2'd2, 1'b0);
      @(negedge clk);
      chk("rstacc_wen_before", {31'h0, m_wen}, 32'h1);
      rst_n = 1'b0;
      #1;
      chk("rstacc_wen", {31'h0, m_wen}, 32'h0);
      chk("rstacc_waddr", m_waddr, 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rstacc_req_ready", {31'h0, req_ready}, 32'h1);
      chk("rstacc_resp_valid", {31'h0, resp_valid}, 32'h0);
      chk("rstacc_mem", mem[3], 32'h0);
      load_chk("post_rst_lw", 32'h80000004, 2'd2, 1'b0, 32'hDEADBEEF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
